// File: rtl/mips_mem_pkg.sv
// Shared constants for the data-side memory responder: MMIO register
// offsets, TXSTAT field positions and the default MMIO window base.
package mips_mem_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

    // Byte offsets of the MMIO registers inside the 16-byte window
    localparam logic [3:0] MMIO_CYCLE  = 4'h0;
    localparam logic [3:0] MMIO_TXDATA = 4'h4;
    localparam logic [3:0] MMIO_TXSTAT = 4'h8;
    localparam logic [3:0] MMIO_HALT   = 4'hC;

    // TXSTAT field positions; the count field starts at TXSTAT_COUNT_LSB
    // and is log2(FIFO_DEPTH)+1 bits wide
    localparam int TXSTAT_FULL      = 0;
    localparam int TXSTAT_EMPTY     = 1;
    localparam int TXSTAT_COUNT_LSB = 2;
    localparam int TXSTAT_OVF       = 31;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous output FIFO. A push into a full FIFO is still accepted when a
// pop happens in the same cycle, so count stays unchanged. Storage is not
// reset; only pointers and count are. The head reads 0 when empty.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [W-1:0]  data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          accept_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o  = (count_q == '0);
    assign full_o   = (count_q == CW'(DEPTH));
    assign do_pop   = pop_i && !empty_o;
    assign do_push  = push_i && (!full_o || do_pop);
    assign accept_o = do_push;
    assign count_o  = count_q;
    assign head_o   = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/data_mem_mmio.sv
// Data-side memory responder: word RAM plus a 16-byte MMIO window holding a
// cycle counter, a FIFO-backed output port and a sticky halt flag.
module data_mem_mmio
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] adr,
    input  logic [31:0] d_in,
    input  logic        mrd,
    input  logic        mwr,
    output logic [31:0] d_out,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        halt
);

    localparam int          AW        = $clog2(DEPTH);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    logic [31:0]   ram_q [DEPTH];
    logic [31:0]   cycle_q, cycle_d;
    logic          halt_q, halt_d;
    logic          ovf_q, ovf_d;

    logic          mmio_hit;
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic [3:0]    reg_off;
    logic          tx_push;
    logic          fifo_pop;
    logic          fifo_accept;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   txstat;
    logic [31:0]   rd_val;

    // MMIO takes priority; RAM covers the low 4*DEPTH bytes
    assign mmio_hit = (adr[31:4] == MMIO_BASE[31:4]);
    assign ram_hit  = !mmio_hit && (adr < RAM_BYTES);
    assign ram_idx  = adr[AW+1:2];
    assign reg_off  = {adr[3:2], 2'b00};

    // MMIO writes are ignored while reset is asserted
    assign tx_push  = !rst && mwr && mmio_hit && (reg_off == MMIO_TXDATA);
    assign fifo_pop = out_valid && out_ready;

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_tx_fifo (
        .clk_i    (clk),
        .rst_i    (rst),
        .push_i   (tx_push),
        .data_i   (d_in),
        .pop_i    (fifo_pop),
        .head_o   (out_data),
        .count_o  (fifo_count),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .accept_o (fifo_accept)
    );

    assign out_valid = !fifo_empty;
    assign halt      = halt_q;

    // RAM write port; RAM keeps its contents and accepts writes through reset
    always_ff @(posedge clk) begin
        if (mwr && ram_hit) ram_q[ram_idx] <= d_in;
    end

    // Next state of counter, halt flag and sticky overflow
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        halt_d  = halt_q;
        ovf_d   = ovf_q;
        if (mwr && mmio_hit && (reg_off == MMIO_HALT)) halt_d = 1'b1;
        if (tx_push && !fifo_accept)                   ovf_d  = 1'b1;
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q <= '0;
            halt_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            halt_q  <= halt_d;
            ovf_q   <= ovf_d;
        end
    end

    // TXSTAT packing: full, empty, count, sticky overflow
    always_comb begin
        txstat                              = '0;
        txstat[TXSTAT_FULL]                 = fifo_full;
        txstat[TXSTAT_EMPTY]                = fifo_empty;
        txstat[TXSTAT_COUNT_LSB +: CW]      = fifo_count;
        txstat[TXSTAT_OVF]                  = ovf_q;
    end

    // Combinational read mux; unmapped and write-only locations read 0
    always_comb begin
        rd_val = '0;
        if (mmio_hit) begin
            case (reg_off)
                MMIO_CYCLE:  rd_val = cycle_q;
                MMIO_TXSTAT: rd_val = txstat;
                MMIO_HALT:   rd_val = {31'b0, halt_q};
                default:     rd_val = '0;
            endcase
        end else if (ram_hit) begin
            rd_val = ram_q[ram_idx];
        end
    end

    assign d_out = mrd ? rd_val : '0;

endmodule
